// File: rtl/fifo_read_sched.sv
// Read-side scheduler for the frame FIFO: pops one word, launches it to the
// serial output stage, waits for serialisation plus an idle gap, then repeats.
module fifo_read_sched #(
    parameter int FIFO_LAT = 1,
    parameter int GAP_CYC  = 2,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             ctrl_enable,
    input  logic             fifo_empty,
    output logic             fifo_r_enable,
    input  logic [7:0]       vld_ch,
    input  logic [15:0]      data_count,
    input  logic             out_busy,
    output logic             frame_start,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [2:0]       sched_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_LAUNCH = 3'd3,
        S_BUSY   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam int              WD_W     = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [1:0]      LAT_LOAD = 2'(FIFO_LAT - 1);
    localparam logic [7:0]      GAP_LOAD = 8'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
    localparam state_t          POST     = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    state_t            state_q, state_d;
    logic [1:0]        lat_q, lat_d;
    logic [7:0]        gap_q, gap_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              seen_q, seen_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              start_q, start_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        gap_d   = gap_q;
        wd_d    = wd_q;
        seen_d  = seen_q;
        sent_d  = sent_q;
        drop_d  = drop_q;
        err_d   = err_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        if (err_clr) err_d = 1'b0;

        case (state_q)
            S_IDLE: if (ctrl_enable && !fifo_empty) state_d = S_READ;
            S_READ: begin
                state_d = S_WAIT;
                lat_d   = LAT_LOAD;
            end
            S_WAIT: begin
                // FIFO word is valid on this last WAIT edge; deciding here lets
                // frame_start be a register that is high during LAUNCH itself.
                if (lat_q == 2'd0) begin
                    state_d = S_LAUNCH;
                    start_d = (|vld_ch) && (|data_count);
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_LAUNCH: begin
                if (start_q) begin
                    sent_d  = sent_q + 1'b1;
                    seen_d  = 1'b0;
                    wd_d    = '0;
                    state_d = S_BUSY;
                end else begin
                    drop_d  = drop_q + 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = POST;
                end
            end
            S_BUSY: begin
                seen_d = seen_q | out_busy;
                // Normal completion is tested first so it wins a tie with the watchdog.
                if (!out_busy && seen_q) begin
                    done_d  = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = POST;
                end else if (wd_q == WD_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = POST;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        rd_d = (state_d == S_READ);
    end

    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
            seen_q  <= 1'b0;
            sent_q  <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            seen_q  <= seen_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign fifo_r_enable  = rd_q;
    assign frame_start    = start_q;
    assign frame_done     = done_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = drop_q;
    assign timeout_err    = err_q;
    assign sched_state    = state_q;

endmodule
